// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register carrying a PC/instruction pair.
// Registered in_ready and out_valid break the combinational ready path between stages.
module pipe_stage_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 'h13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // Handshake: an entry moves on a rising edge where valid && ready are both
  // high and flush is low; valid never waits on ready, and a held entry keeps
  // its data stable until it is taken. flush wins over accept and pop.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [PC_W-1:0]      head_pc, head_pc_nxt;
  logic [INSTR_W-1:0]   head_instr, head_instr_nxt;
  logic [PC_W-1:0]      skid_pc, skid_pc_nxt;
  logic [INSTR_W-1:0]   skid_instr, skid_instr_nxt;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 accept;
  logic                 pop;

  assign accept = in_valid && in_ready_q && !flush;
  assign pop    = out_valid_q && out_ready && !flush;

  always_comb begin
    state_nxt      = state;
    head_pc_nxt    = head_pc;
    head_instr_nxt = head_instr;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;

    if (flush) begin
      state_nxt      = EMPTY;
      head_pc_nxt    = '0;
      head_instr_nxt = NOP_INSTR;
      skid_pc_nxt    = '0;
      skid_instr_nxt = NOP_INSTR;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt      = ONE;
            head_pc_nxt    = in_pc;
            head_instr_nxt = in_instr;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_nxt      = FULL;
            skid_pc_nxt    = in_pc;
            skid_instr_nxt = in_instr;
          end else if (accept && pop) begin
            head_pc_nxt    = in_pc;
            head_instr_nxt = in_instr;
          end else if (pop) begin
            // Empty head is parked at the idle values so outputs need no mux.
            state_nxt      = EMPTY;
            head_pc_nxt    = '0;
            head_instr_nxt = NOP_INSTR;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt      = ONE;
            head_pc_nxt    = skid_pc;
            head_instr_nxt = skid_instr;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
          end
        end
        default: begin
          state_nxt      = EMPTY;
          head_pc_nxt    = '0;
          head_instr_nxt = NOP_INSTR;
          skid_pc_nxt    = '0;
          skid_instr_nxt = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      head_pc     <= '0;
      head_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      skid_instr  <= NOP_INSTR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      head_pc     <= head_pc_nxt;
      head_instr  <= head_instr_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_instr  <= skid_instr_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // The state encoding is the entry count, so occupancy doubles as the FSM debug view.
  assign occupancy = state;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = head_pc;
  assign out_instr = head_instr;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: default 32/32 instance plus a 64/16 instance.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Default-parameter instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occupancy;

  pipe_stage_reg dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy)
  );

  // Wide-PC / narrow-instruction instance
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [63:0] w_in_pc = '0;
  logic [15:0] w_in_instr = '0;
  logic        w_flush = 1'b0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [63:0] w_out_pc;
  logic [15:0] w_out_instr;
  logic [1:0]  w_occupancy;

  pipe_stage_reg #(.PC_W(64), .INSTR_W(16), .NOP_INSTR(16'h0001)) dut_w (
    .clock(clock), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_pc(w_in_pc), .in_instr(w_in_instr),
    .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
    .occupancy(w_occupancy)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];   // {pc, instr}, head at index 0

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : {32'h0, NOP};
    check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_q.size() > 0));
    check({tag, ".out_pc"},    64'(out_pc),    64'(head[63:32]));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(head[31:0]));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(exp_q.size()));
    check({tag, ".in_ready"},  64'(in_ready),  64'(exp_q.size() < 2));
  endtask

  // Called just after a rising edge: drives inputs, checks outputs at the falling
  // edge, then advances the model for the coming rising edge.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ordy, input logic fl);
    logic do_pop, do_acc;
    in_valid = v; in_pc = pc; in_instr = instr; out_ready = ordy; flush = fl;
    @(negedge clock);
    check_outputs(tag);
    if (fl) begin
      exp_q.delete();
    end else begin
      do_pop = (exp_q.size() > 0) && ordy;
      do_acc = v && (exp_q.size() < 2);
      if (do_pop) begin
        check({tag, ".pop_pc"},    64'(out_pc),    64'(exp_q[0][63:32]));
        check({tag, ".pop_instr"}, 64'(out_instr), 64'(exp_q[0][31:0]));
        void'(exp_q.pop_front());
      end
      if (do_acc) exp_q.push_back({pc, instr});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state (reset held low from time 0)
    #12;
    check_outputs("reset");
    check("w_reset.out_instr", 64'(w_out_instr), 64'h0001);
    check("w_reset.out_pc", w_out_pc, 64'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Single entry, 1-cycle latency, accepted on first edge after reset
    step("first", 1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
    step("first_out", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back stream
    for (int i = 0; i < 4; i++)
      step("stream", 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    step("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("stream_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill with stall, then drain
    step("stall", 1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    step("stall", 1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0);
    step("full_hold", 1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0);
    step("full_hold", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("drain_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a coincident input
    step("pre_flush", 1'b1, 32'h20, 32'h2222_0020, 1'b0, 1'b0);
    step("pre_flush", 1'b1, 32'h24, 32'h2222_0024, 1'b0, 1'b0);
    step("flush", 1'b1, 32'h28, 32'h2222_0028, 1'b1, 1'b1);
    step("post_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush.out_instr_nop", 64'(out_instr), 64'(NOP));

    // Asynchronous reset mid-operation
    step("pre_reset", 1'b1, 32'h30, 32'h3333_0030, 1'b0, 1'b0);
    step("hold_one", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check_outputs("async_reset");
    @(posedge clock);
    #1 reset = 1'b1;
    step("after_reset", 1'b1, 32'h40, 32'h4444_0040, 1'b0, 1'b0);
    step("after_reset_out", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("after_reset_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < 3; i++)
      step("rand_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wide instance: full-width PC, narrow NOP
    w_in_valid = 1'b1; w_in_pc = 64'hFFFF_FFFF_0000_0004; w_in_instr = 16'hBEEF;
    @(negedge clock);
    check("w_empty.out_instr", 64'(w_out_instr), 64'h0001);
    @(posedge clock); #1;
    w_in_valid = 1'b0;
    @(negedge clock);
    check("w_one.out_valid", 64'(w_out_valid), 64'h1);
    check("w_one.out_pc", w_out_pc, 64'hFFFF_FFFF_0000_0004);
    check("w_one.out_instr", 64'(w_out_instr), 64'hBEEF);
    check("w_one.occupancy", 64'(w_occupancy), 64'h1);
    w_out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("w_popped.out_valid", 64'(w_out_valid), 64'h0);
    check("w_popped.out_pc", w_out_pc, 64'h0);
    check("w_popped.out_instr", 64'(w_out_instr), 64'h0001);
    check("w_popped.in_ready", 64'(w_in_ready), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
